// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//
// Command front-end for the unsigned ALU. Commands (opcode, A, B) are queued
// in a small FIFO and issued one at a time: the ALU's set strobe is pulsed for
// one cycle, the registered ALU result and flags are captured one cycle later,
// and they are returned on a valid/ready response channel. Opcodes 14 and 15
// are illegal: they are answered with rsp_error=1 and the ALU is never strobed.
//
// Optional build macro: ALU_SEQ_STATS_EN adds saturating response counters
// (stat_ops, stat_ovf, stat_unf).
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (cmd_opcode, cmd_a, cmd_b)
//   rsp_valid/rsp_ready           response handshake (rsp_result, rsp_overflow,
//                                 rsp_underflow, rsp_error)
//   alu_opcode/alu_a/alu_b        held command driven to the ALU
//   alu_set, alu_reset            ALU strobe and reset
//   alu_out/alu_overflow/
//   alu_underflow                 registered ALU outputs
//   stat_ops/stat_ovf/stat_unf    response counters (ALU_SEQ_STATS_EN only)
//   busy                          FSM active or FIFO holding commands
//
// state  | meaning
// IDLE   | waiting for a queued command; pops the FIFO head when one is present
// ISSUE  | alu_set high for one cycle with the held command
// WAIT   | ALU result registered; captured into the response registers
// RESP   | response presented until rsp_ready

module alu_op_sequencer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_underflow,
    output logic             rsp_error,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_set,
    output logic             alu_reset,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_overflow,
    input  logic             alu_underflow,
`ifdef ALU_SEQ_STATS_EN
    output logic [15:0]      stat_ops,
    output logic [15:0]      stat_ovf,
    output logic [15:0]      stat_unf,
`endif
    output logic             busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0]       opcode;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } cmd_t;

    state_t           state_q, state_d;
    cmd_t             fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    cmd_t             head;
    cmd_t             held_q;
    logic             push, pop, head_illegal, capture, rsp_done;

    // ---------------- FIFO ----------------
    assign cmd_ready    = (count < CNT_W'(DEPTH));
    assign push         = cmd_valid && cmd_ready;
    assign pop          = (state_q == S_IDLE) && (count != '0);
    assign head         = fifo_mem[rd_ptr];
    assign head_illegal = (head.opcode > 4'd13);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{opcode: cmd_opcode, a: cmd_a, b: cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (count != '0) state_d = head_illegal ? S_RESP : S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign capture  = (state_q == S_WAIT);
    assign rsp_done = (state_q == S_RESP) && rsp_ready;

    // Held command and response registers. Error responses are loaded at pop
    // time since the ALU is skipped entirely for them.
    always_ff @(posedge clk) begin
        if (reset) begin
            held_q        <= '0;
            rsp_result    <= '0;
            rsp_overflow  <= 1'b0;
            rsp_underflow <= 1'b0;
            rsp_error     <= 1'b0;
        end else begin
            if (pop) begin
                held_q <= head;
                if (head_illegal) begin
                    rsp_result    <= '0;
                    rsp_overflow  <= 1'b0;
                    rsp_underflow <= 1'b0;
                    rsp_error     <= 1'b1;
                end
            end
            if (capture) begin
                rsp_result    <= alu_out;
                rsp_overflow  <= alu_overflow;
                rsp_underflow <= alu_underflow;
                rsp_error     <= 1'b0;
            end
        end
    end

    assign rsp_valid  = (state_q == S_RESP);
    assign alu_set    = (state_q == S_ISSUE);
    assign alu_opcode = held_q.opcode;
    assign alu_a      = held_q.a;
    assign alu_b      = held_q.b;
    // Pass-through so the ALU clears in the same cycle as this block.
    assign alu_reset  = reset;
    assign busy       = (state_q != S_IDLE) || (count != '0);

`ifdef ALU_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_ops <= '0;
            stat_ovf <= '0;
            stat_unf <= '0;
        end else if (rsp_done) begin
            if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
            if (rsp_overflow && stat_ovf != 16'hFFFF) stat_ovf <= stat_ovf + 16'd1;
            if (rsp_underflow && stat_unf != 16'hFFFF) stat_unf <= stat_unf + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer. Contains a stand-in registered ALU:
// 0 ADD, 1 SUB, 2 INC, 3 DEC, 4 AND, 5 OR, 6 XOR, 12 rotate-left, others 0.
module tb_alu_op_sequencer;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid, cmd_ready;
    logic [3:0]       cmd_opcode;
    logic [WIDTH-1:0] cmd_a, cmd_b;
    logic             rsp_valid, rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_overflow, rsp_underflow, rsp_error;
    logic [3:0]       alu_opcode;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic             alu_set, alu_reset;
    logic [WIDTH-1:0] alu_out;
    logic             alu_overflow, alu_underflow;
    logic             busy;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0]      stat_ops, stat_ovf, stat_unf;
`endif

    alu_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
        .rsp_underflow(rsp_underflow), .rsp_error(rsp_error),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_set(alu_set), .alu_reset(alu_reset),
        .alu_out(alu_out), .alu_overflow(alu_overflow), .alu_underflow(alu_underflow),
`ifdef ALU_SEQ_STATS_EN
        .stat_ops(stat_ops), .stat_ovf(stat_ovf), .stat_unf(stat_unf),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // returns {overflow, underflow, out}
    function automatic logic [5:0] alu_calc(input logic [3:0] op, input logic [3:0] a,
                                            input logic [3:0] b);
        logic [4:0] s;
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; return {s[4], 1'b0, s[3:0]}; end
            4'd1: return {1'b0, (a < b), 4'(a - b)};
            4'd2: return {(a == 4'hF), 1'b0, 4'(a + 4'd1)};
            4'd3: return {1'b0, (a == 4'h0), 4'(a - 4'd1)};
            4'd4: return {2'b00, a & b};
            4'd5: return {2'b00, a | b};
            4'd6: return {2'b00, a ^ b};
            4'd12: return {2'b00, a[2:0], a[3]};
            default: return 6'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_reset) begin
            alu_out       <= '0;
            alu_overflow  <= 1'b0;
            alu_underflow <= 1'b0;
        end else if (alu_set) begin
            {alu_overflow, alu_underflow, alu_out} <= alu_calc(alu_opcode, alu_a, alu_b);
        end
    end

    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       ovf;
        logic       unf;
        logic       err;
    } vec_t;

    vec_t vecs [9];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive_cmd(input vec_t v);
        cmd_valid  = 1'b1;
        cmd_opcode = v.op;
        cmd_a      = v.a;
        cmd_b      = v.b;
    endtask

    // One command into an idle block; checks latency, strobe timing and payload.
    task automatic run_vec(input vec_t v, input string tag);
        int  lat, set_cnt, set_lat;
        bit  done;
        lat = 0; set_cnt = 0; set_lat = 0; done = 0;
        @(negedge clk);
        drive_cmd(v);
        while (!done && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            cmd_valid = 1'b0;
            if (alu_set) begin set_cnt++; set_lat = lat; end
            if (rsp_valid) done = 1;
        end
        chk({tag, ".latency"}, 32'(lat), v.err ? 32'd2 : 32'd4);
        chk({tag, ".result"}, 32'(rsp_result), 32'(v.res));
        chk({tag, ".overflow"}, 32'(rsp_overflow), 32'(v.ovf));
        chk({tag, ".underflow"}, 32'(rsp_underflow), 32'(v.unf));
        chk({tag, ".error"}, 32'(rsp_error), 32'(v.err));
        chk({tag, ".set_pulses"}, 32'(set_cnt), v.err ? 32'd0 : 32'd1);
        if (!v.err) begin
            chk({tag, ".set_cycle"}, 32'(set_lat), 32'd2);
            chk({tag, ".alu_opcode_held"}, 32'(alu_opcode), 32'(v.op));
            chk({tag, ".alu_a_held"}, 32'(alu_a), 32'(v.a));
        end
        @(negedge clk);
        chk({tag, ".rsp_valid_after_accept"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".busy_after_accept"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{op: 4'd0,  a: 4'd9,  b: 4'd8,  res: 4'd1,  ovf: 1, unf: 0, err: 0};
        vecs[1] = '{op: 4'd1,  a: 4'd3,  b: 4'd5,  res: 4'd14, ovf: 0, unf: 1, err: 0};
        vecs[2] = '{op: 4'd12, a: 4'd9,  b: 4'd0,  res: 4'd3,  ovf: 0, unf: 0, err: 0};
        vecs[3] = '{op: 4'd15, a: 4'd7,  b: 4'd7,  res: 4'd0,  ovf: 0, unf: 0, err: 1};
        vecs[4] = '{op: 4'd2,  a: 4'd15, b: 4'd0,  res: 4'd0,  ovf: 1, unf: 0, err: 0};
        vecs[5] = '{op: 4'd4,  a: 4'd12, b: 4'd10, res: 4'd8,  ovf: 0, unf: 0, err: 0};
        vecs[6] = '{op: 4'd14, a: 4'd1,  b: 4'd2,  res: 4'd0,  ovf: 0, unf: 0, err: 1};
        vecs[7] = '{op: 4'd0,  a: 4'd3,  b: 4'd4,  res: 4'd7,  ovf: 0, unf: 0, err: 0};
        vecs[8] = '{op: 4'd3,  a: 4'd0,  b: 4'd0,  res: 4'd15, ovf: 0, unf: 1, err: 0};

        reset = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("reset.alu_reset", 32'(alu_reset), 32'd1);
        @(negedge clk);
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.alu_set", 32'(alu_set), 32'd0);
        chk("reset.alu_opcode", 32'(alu_opcode), 32'd0);
        chk("reset.rsp_result", 32'(rsp_result), 32'd0);
        chk("reset.rsp_error", 32'(rsp_error), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: six back-to-back commands with rsp_ready low.
        begin
            int  n_acc, n_rsp;
            logic rdy;
            n_acc = 0; n_rsp = 0;
            rsp_ready = 1'b0;
            for (int cyc = 0; cyc < 200 && n_rsp < 6; cyc++) begin
                @(negedge clk);
                if (cyc == 8) begin
                    chk("bp.accepted_while_stalled", 32'(n_acc), 32'd5);
                    chk("bp.cmd_ready_full", 32'(cmd_ready), 32'd0);
                    chk("bp.busy", 32'(busy), 32'd1);
                    rsp_ready = 1'b1;
                end
                if (n_acc < 6) drive_cmd(vecs[n_acc]);
                else           cmd_valid = 1'b0;
                rdy = cmd_ready;
                if (rsp_valid && rsp_ready) begin
                    chk($sformatf("bp.rsp%0d.result", n_rsp), 32'(rsp_result), 32'(vecs[n_rsp].res));
                    chk($sformatf("bp.rsp%0d.flags", n_rsp),
                        32'({rsp_error, rsp_overflow, rsp_underflow}),
                        32'({vecs[n_rsp].err, vecs[n_rsp].ovf, vecs[n_rsp].unf}));
                    n_rsp++;
                end
                @(posedge clk);
                if (cmd_valid && rdy) n_acc++;
            end
            chk("bp.responses_received", 32'(n_rsp), 32'd6);
            @(negedge clk);
            cmd_valid = 1'b0;
            @(negedge clk);
            chk("bp.idle_after", 32'(busy), 32'd0);
        end

        // Reset while in WAIT with two commands queued.
        begin
            int stale_rsp, stale_set;
            stale_rsp = 0; stale_set = 0;
            rsp_ready = 1'b1;
            @(negedge clk); drive_cmd(vecs[0]);
            @(negedge clk); drive_cmd(vecs[7]);
            @(negedge clk); drive_cmd(vecs[5]);
            chk("rst.issue_seen", 32'(alu_set), 32'd1);
            @(negedge clk);
            cmd_valid = 1'b0;
            reset     = 1'b1;
            chk("rst.alu_reset_passthru", 32'(alu_reset), 32'd1);
            @(negedge clk);
            reset = 1'b0;
            chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
            chk("rst.busy", 32'(busy), 32'd0);
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (rsp_valid) stale_rsp++;
                if (alu_set)   stale_set++;
            end
            chk("rst.stale_responses", 32'(stale_rsp), 32'd0);
            chk("rst.stale_strobes", 32'(stale_set), 32'd0);
        end

`ifdef ALU_SEQ_STATS_EN
        do_reset();
        chk("stats.ops_after_reset", 32'(stat_ops), 32'd0);
        run_vec(vecs[0], "stats.add");
        run_vec(vecs[1], "stats.sub");
        run_vec(vecs[3], "stats.illegal");
        run_vec(vecs[5], "stats.and");
        chk("stats.ops", 32'(stat_ops), 32'd4);
        chk("stats.ovf", 32'(stat_ovf), 32'd1);
        chk("stats.unf", 32'(stat_unf), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command front-end that sits directly upstream of the unsigned ALU.
- Buffers incoming ALU commands (opcode, A, B) in a small FIFO and issues them one at a time to the ALU by pulsing its set strobe.
- Captures the registered ALU result and its overflow/underflow flags, then returns them on a valid/ready response channel.
- Lets producers stream operations without tracking the ALU's one-cycle registered latency.

Parameters:
- WIDTH, 4: operand and result width; must equal the ALU's WIDTH.
- DEPTH, 4: command FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept a command
- cmd_opcode  in  4  ALU opcode
- cmd_a  in  WIDTH  operand A
- cmd_b  in  WIDTH  operand B
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  WIDTH  captured ALU out
- rsp_overflow  out  1  captured ALU overflow
- rsp_underflow  out  1  captured ALU underflow
- rsp_error  out  1  opcode was illegal (14/15); command not issued
- alu_opcode  out  4  to ALU opcode
- alu_a  out  WIDTH  to ALU A
- alu_b  out  WIDTH  to ALU B
- alu_set  out  1  to ALU set
- alu_reset  out  1  to ALU reset
- alu_out  in  WIDTH  from ALU out
- alu_overflow  in  1  from ALU overflow
- alu_underflow  in  1  from ALU underflow
- busy  out  1  FSM not in IDLE, or FIFO not empty

Behaviour:
- Clocking and reset: reset is synchronous and active-high; clk is the clock.
- Reset values:
  - FIFO is emptied (pointers 0, count 0) and FSM goes to IDLE.
  - rsp_valid=0; rsp_result, rsp_overflow, rsp_underflow and rsp_error are 0.
  - alu_set=0; alu_opcode, alu_a and alu_b are 0; busy=0.
  - alu_reset = reset (combinational pass-through), so the ALU clears in the same cycle.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready = (count < DEPTH); it depends only on count, so a pop in the same cycle does not free a slot early.
  - Pointers wrap modulo DEPTH.
  - Count width is clog2(DEPTH+1).
  - Simultaneous push and pop leaves count unchanged.
- FSM, with states IDLE, ISSUE, WAIT, RESP:
  - IDLE: if the FIFO is non-empty, pop the head into a held command register.
    - If opcode > 13, load rsp_error=1, rsp_result=0 and both flags 0, then go to RESP. The ALU is never strobed.
    - Otherwise go to ISSUE.
  - ISSUE: alu_set=1 for exactly one cycle, with alu_opcode, alu_a and alu_b driven from the held command. Go to WAIT.
  - WAIT: the ALU outputs now hold the result. Capture alu_out, alu_overflow and alu_underflow into the rsp registers with rsp_error=0. Go to RESP.
  - RESP: rsp_valid=1 and rsp outputs stay stable until rsp_ready is seen. On rsp_valid && rsp_ready go to IDLE.
- alu_opcode, alu_a and alu_b are held constant from ISSUE through RESP and change only on the next pop. alu_set is 0 outside ISSUE.
- Latency, for a push at cycle 0 into an empty, idle block:
  - pop in IDLE at cycle 1;
  - alu_set high at cycle 2;
  - capture at cycle 3;
  - rsp_valid high from cycle 4.
  - Peak throughput is one command per 4 cycles.
- The block performs no arithmetic of its own; result width and flag semantics are exactly the ALU's.
- Reset mid-operation (any state): the in-flight command and all FIFO contents are discarded, and no response is produced for them.

Optional Feature:
- Macro: ALU_SEQ_STATS_EN.
- With it defined, three extra outputs are added:
  - stat_ops [15:0]: counts completed responses, including error responses.
  - stat_ovf [15:0]: counts responses with rsp_overflow=1.
  - stat_unf [15:0]: counts responses with rsp_underflow=1.
- The counters increment on the rsp_valid && rsp_ready handshake, saturate at 16'hFFFF, and clear on reset.
- Without it defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- ADD, opcode 0, A=9, B=8, WIDTH=4 -> alu_set pulses once 2 cycles after the push; response has rsp_result=1, rsp_overflow=1, rsp_underflow=0; rsp_valid first high 4 cycles after the push.
- SUB, opcode 1, A=3, B=5 -> rsp_result=14, rsp_underflow=1, rsp_overflow=0. Then RL, opcode 12, A=4'b1001 -> rsp_result=4'b0011 with both flags 0.
- With rsp_ready held 0, push 6 commands back-to-back -> the first is popped, then 4 more fill the FIFO and cmd_ready drops after the 5th accepted push; the 6th is held. Release rsp_ready -> all 6 responses arrive in order with correct values.
- Opcode 15, A=7, B=7 -> rsp_error=1, rsp_result=0, and alu_set stays 0 throughout; the next legal command (INC, A=15) returns result 0 with overflow=1.
- Assert reset during WAIT with 2 commands queued -> the next cycle shows rsp_valid=0, cmd_ready=1, busy=0; no stale responses appear afterwards.
- ALU_SEQ_STATS_EN build, running the sequence ADD overflow, SUB underflow, illegal opcode, AND -> stat_ops=4, stat_ovf=1, stat_unf=1.
